// File: rtl/sreg_block_loader_ctrl.sv
// Sequencer for the 4-lane 512-bit block shift register: counts beats per block, presents blocks, tracks message progress.
// Optional macro SREG_CTRL_STALL_CNT_EN adds a saturating count of back-pressured PRESENT cycles.
`default_nettype none

module sreg_block_loader_ctrl #(
    parameter int BEATS = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_blocks_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             sreg_en_o,
    output logic             blk_valid_o,
    input  logic             blk_ready_i,
    output logic             blk_last_o,
    output logic [CNT_W-1:0] blk_idx_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SREG_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt_o
`endif
);

    localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] blk_idx_q, blk_idx_d;
    logic [CNT_W-1:0] num_lat_q, num_lat_d;
    logic             done_q, done_d;
    logic             is_last;
    logic             accept;

    assign is_last = (blk_idx_q == (num_lat_q - CNT_W'(1)));
    // abort masks the handshake so a beat offered in the abort cycle is dropped
    assign accept  = (state_q == FILL) && in_valid_i && !abort_i;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        blk_idx_d  = blk_idx_q;
        num_lat_d  = num_lat_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_blocks_i != '0) begin
                        num_lat_d  = num_blocks_i;
                        blk_idx_d  = '0;
                        beat_cnt_d = '0;
                        state_d    = FILL;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (abort_i) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    blk_idx_d  = '0;
                end else if (accept) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = PRESENT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
                end
            end
            PRESENT: begin
                if (abort_i) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    blk_idx_d  = '0;
                end else if (blk_ready_i) begin
                    if (is_last) begin
                        state_d   = IDLE;
                        blk_idx_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        blk_idx_d = blk_idx_q + CNT_W'(1);
                        state_d   = FILL;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
                blk_idx_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            blk_idx_q  <= '0;
            num_lat_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            blk_idx_q  <= blk_idx_d;
            num_lat_q  <= num_lat_d;
            done_q     <= done_d;
        end
    end

    assign in_ready_o  = (state_q == FILL) && !abort_i;
    assign sreg_en_o   = accept;
    assign blk_valid_o = (state_q == PRESENT);
    assign blk_last_o  = (state_q == PRESENT) && is_last;
    assign blk_idx_o   = blk_idx_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

`ifdef SREG_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start_i) begin
            stall_cnt_d = '0;
        end else if (state_q == PRESENT && !blk_ready_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sreg_block_loader_ctrl.sv
// Directed self-checking bench for sreg_block_loader_ctrl.
`default_nettype none

module tb_sreg_block_loader_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] num_blocks_i = 8'd0;
    logic       abort_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic       sreg_en_o;
    logic       blk_valid_o;
    logic       blk_ready_i = 1'b0;
    logic       blk_last_o;
    logic [7:0] blk_idx_o;
    logic       busy_o;
    logic       done_o;
`ifdef SREG_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int en_base;

    sreg_block_loader_ctrl #(.BEATS(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .num_blocks_i (num_blocks_i),
        .abort_i      (abort_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .sreg_en_o    (sreg_en_o),
        .blk_valid_o  (blk_valid_o),
        .blk_ready_i  (blk_ready_i),
        .blk_last_o   (blk_last_o),
        .blk_idx_o    (blk_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef SREG_CTRL_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sreg_en_o === 1'b1) en_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready_o),  0);
        chk({tag, "_sreg_en"},   32'(sreg_en_o),   0);
        chk({tag, "_blk_valid"}, 32'(blk_valid_o), 0);
        chk({tag, "_blk_last"},  32'(blk_last_o),  0);
        chk({tag, "_blk_idx"},   32'(blk_idx_o),   0);
        chk({tag, "_busy"},      32'(busy_o),      0);
        chk({tag, "_done"},      32'(done_o),      0);
    endtask

    initial begin
        // Reset state
        #1;
        chk_all_zero("reset");
        #11 rst_n = 1'b1;
        tick();
        chk_all_zero("idle");

        // Single block, in_valid held high
        en_base = en_cnt;
        start_i = 1'b1; num_blocks_i = 8'd1;
        tick();
        start_i = 1'b0; in_valid_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_sreg_en", 32'(sreg_en_o), 1);
            chk("t1_busy", 32'(busy_o), 1);
            chk("t1_blk_valid_low", 32'(blk_valid_o), 0);
            tick();
        end
        chk("t1_blk_valid", 32'(blk_valid_o), 1);
        chk("t1_blk_last", 32'(blk_last_o), 1);
        chk("t1_blk_idx", 32'(blk_idx_o), 0);
        chk("t1_sreg_en_present", 32'(sreg_en_o), 0);
        chk("t1_in_ready_present", 32'(in_ready_o), 0);
        chk("t1_en_count", 32'(en_cnt - en_base), 4);
        in_valid_i = 1'b0; blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        chk("t1_done", 32'(done_o), 1);
        chk("t1_busy_fall", 32'(busy_o), 0);
        chk("t1_blk_valid_fall", 32'(blk_valid_o), 0);
        tick();
        chk("t1_done_once", 32'(done_o), 0);

        // Three blocks, in_valid toggling
        en_base = en_cnt;
        start_i = 1'b1; num_blocks_i = 8'd3;
        tick();
        start_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) begin
                in_valid_i = (i % 2 == 0);
                tick();
            end
            in_valid_i = 1'b0;
            chk("t2_blk_valid", 32'(blk_valid_o), 1);
            chk("t2_blk_idx", 32'(blk_idx_o), 32'(b));
            chk("t2_blk_last", 32'(blk_last_o), (b == 2) ? 1 : 0);
            chk("t2_done_low", 32'(done_o), 0);
            blk_ready_i = 1'b1;
            tick();
            blk_ready_i = 1'b0;
        end
        chk("t2_done", 32'(done_o), 1);
        chk("t2_en_count", 32'(en_cnt - en_base), 12);

        // Back-pressure: block held for 10 cycles
        tick();
        start_i = 1'b1; num_blocks_i = 8'd1;
        tick();
        start_i = 1'b0; in_valid_i = 1'b1;
        repeat (4) tick();
        en_base = en_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("t3_blk_valid", 32'(blk_valid_o), 1);
            chk("t3_in_ready", 32'(in_ready_o), 0);
            chk("t3_sreg_en", 32'(sreg_en_o), 0);
            tick();
        end
        chk("t3_en_none", 32'(en_cnt - en_base), 0);
`ifdef SREG_CTRL_STALL_CNT_EN
        chk("t3_stall_cnt", 32'(stall_cnt_o), 10);
`endif
        in_valid_i = 1'b0; blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        chk("t3_done", 32'(done_o), 1);
        tick();
`ifdef SREG_CTRL_STALL_CNT_EN
        chk("t3_stall_hold", 32'(stall_cnt_o), 10);
`endif

        // Abort after 2 beats of block 1
        start_i = 1'b1; num_blocks_i = 8'd2;
        tick();
        start_i = 1'b0; in_valid_i = 1'b1;
        repeat (4) tick();
        in_valid_i = 1'b0; blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        chk("t4_idx1", 32'(blk_idx_o), 1);
        in_valid_i = 1'b1;
        repeat (2) tick();
        abort_i = 1'b1;
        #1;
        chk("t4_abort_in_ready", 32'(in_ready_o), 0);
        chk("t4_abort_sreg_en", 32'(sreg_en_o), 0);
        chk("t4_abort_busy", 32'(busy_o), 1);
        tick();
        abort_i = 1'b0; in_valid_i = 1'b0;
        chk("t4_idle_busy", 32'(busy_o), 0);
        chk("t4_no_done", 32'(done_o), 0);
        chk("t4_idx_clr", 32'(blk_idx_o), 0);
        tick();
        chk("t4_no_done2", 32'(done_o), 0);
        start_i = 1'b1; num_blocks_i = 8'd1;
        tick();
        start_i = 1'b0; in_valid_i = 1'b1;
        repeat (3) tick();
        chk("t4_not_early", 32'(blk_valid_o), 0);
        tick();
        in_valid_i = 1'b0;
        chk("t4_present", 32'(blk_valid_o), 1);
        chk("t4_last", 32'(blk_last_o), 1);
        chk("t4_idx0", 32'(blk_idx_o), 0);
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        chk("t4_done", 32'(done_o), 1);
        tick();

        // Zero-block message
        en_base = en_cnt;
        start_i = 1'b1; num_blocks_i = 8'd0;
        #1;
        chk("t5_busy_now", 32'(busy_o), 0);
        tick();
        start_i = 1'b0;
        chk("t5_done", 32'(done_o), 1);
        chk("t5_busy", 32'(busy_o), 0);
        tick();
        chk("t5_done_once", 32'(done_o), 0);
        chk("t5_busy2", 32'(busy_o), 0);
        chk("t5_no_en", 32'(en_cnt - en_base), 0);

        // Start and abort together in IDLE: start wins
        start_i = 1'b1; abort_i = 1'b1; num_blocks_i = 8'd1;
        tick();
        start_i = 1'b0;
        chk("t6_start_wins", 32'(busy_o), 1);
        tick();
        abort_i = 1'b0;
        chk("t6_abort_fill", 32'(busy_o), 0);

        // Start while busy ignored
        start_i = 1'b1; num_blocks_i = 8'd2;
        tick();
        num_blocks_i = 8'd1; in_valid_i = 1'b1;
        repeat (4) tick();
        start_i = 1'b0; in_valid_i = 1'b0;
        chk("t6_b0_valid", 32'(blk_valid_o), 1);
        chk("t6_b0_not_last", 32'(blk_last_o), 0);
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0; in_valid_i = 1'b1;
        repeat (4) tick();
        in_valid_i = 1'b0;
        chk("t6_b1_idx", 32'(blk_idx_o), 1);
        chk("t6_b1_last", 32'(blk_last_o), 1);
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        chk("t6_done", 32'(done_o), 1);
        tick();

        // Asynchronous reset mid-FILL
        start_i = 1'b1; num_blocks_i = 8'd3;
        tick();
        start_i = 1'b0; in_valid_i = 1'b1;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("t7_rst");
        #1 rst_n = 1'b1;
        in_valid_i = 1'b0;
        tick();
        chk_all_zero("t7_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sreg_block_loader_ctrl.md
Name: sreg_block_loader_ctrl

Overview:
Controller that sequences the 4-lane, 512-bit block shift register. It accepts word-quadruple beats over a valid/ready handshake and drives the shift enable. It counts BEATS beats per block, then presents the completed block to the downstream consumer. It repeats this for a programmed number of blocks per message, and the downstream core reads the 512-bit block only while blk_valid is high.

Parameters:
BEATS, 4, beats (32-bit words per lane) per block; must equal shift-register depth (128/32).
CNT_W, 8, width of block count and block index.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a message; sampled in IDLE only.
num_blocks  input  CNT_W  blocks in message; latched on accepted start.
abort  input  1  synchronous abort; returns to IDLE.
in_valid  input  1  upstream beat (a,b,c,d words) valid.
in_ready  output  1  controller can accept a beat.
sreg_en  output  1  shift enable to block shift register.
blk_valid  output  1  512-bit block complete and stable.
blk_ready  input  1  consumer accepts the block.
blk_last  output  1  presented block is the last of the message.
blk_idx  output  CNT_W  index of block being filled/presented (0-based).
busy  output  1  message in progress.
done  output  1  one-cycle pulse at message completion.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; beat_cnt=0, blk_idx=0, num_lat=0; every output is 0.
- IDLE:
  - in_ready=0, busy=0.
  - start with num_blocks!=0: latch num_blocks, clear blk_idx and beat_cnt, go to FILL.
  - start with num_blocks==0: done=1 on the next cycle; stay in IDLE.
- FILL:
  - in_ready=1, busy=1.
  - sreg_en = in_valid & in_ready, combinational in the same cycle.
  - Each accepted beat increments beat_cnt.
  - Accepting beat BEATS-1: beat_cnt wraps to 0, next state PRESENT.
  - Cycles with in_valid=0 hold state and beat_cnt.
- PRESENT:
  - in_ready=0, sreg_en=0, blk_valid=1, blk_last=(blk_idx==num_lat-1).
  - Block latency: blk_valid rises the cycle after the BEATS-th beat is accepted, so shift-register contents are final when blk_valid is seen.
  - blk_valid and blk_ready high together, not last: blk_idx++, go to FILL.
  - blk_valid and blk_ready high together, last: go to IDLE; done=1 for exactly that next cycle; blk_idx clears to 0.
  - blk_valid stays high until accepted; the shift register is never enabled in PRESENT.
- start while busy: ignored; num_lat unchanged.
- abort (priority over every other event, any state except IDLE): next state IDLE, beat_cnt=0, blk_idx=0, no done pulse. A beat offered in the abort cycle is not accepted: in_ready and sreg_en are forced to 0 combinationally when abort=1. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Reset mid-message: immediate return to IDLE with all outputs 0. The shift register contents are not guaranteed valid afterwards.
- Counters are unsigned. blk_idx never exceeds num_lat-1. num_blocks=2^CNT_W-1 is legal.
- done, blk_valid, in_ready and busy are mutually consistent: done=1 implies busy=0.

Optional Feature:
SREG_CTRL_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt[15:0], counting cycles in PRESENT with blk_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared on accepted start and on reset; holds its value in IDLE.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- start, num_blocks=1, in_valid held high → sreg_en high for exactly 4 cycles; blk_valid rises on cycle 5 with blk_last=1, blk_idx=0; blk_ready=1 → done pulses once; busy falls.
- num_blocks=3, in_valid toggling 1,0,1,0 → 4 accepted beats per block; blk_idx presents 0,1,2; blk_last only on idx 2; 12 total sreg_en pulses.
- Block presented, blk_ready held low 10 cycles → blk_valid stays 1, in_ready=0, sreg_en=0 throughout; with SREG_CTRL_STALL_CNT_EN, stall_cnt=10.
- abort after 2 beats of block 1 (num_blocks=2) → next cycle IDLE, no done, no sreg_en in abort cycle; a new start with num_blocks=1 completes normally.
- start with num_blocks=0 → done one cycle later, busy never asserts, sreg_en never asserts.
- rst low mid-FILL (between clock edges) → all outputs 0 immediately; start while busy ignored (num_lat unchanged, verified by blk_last position).
